// File: rtl/xdma_finish_sender_if.sv
// Single-beat MMIO write port with a write-response return channel.
// master drives the write request and accepts responses; slave is the memory side.
interface xdma_finish_sender_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64
);
  logic                 valid;
  logic                 ready;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] data;
  logic                 rsp_valid;
  logic                 rsp_err;
  logic                 rsp_ready;

  modport master (
    output valid, addr, data, rsp_ready,
    input  ready, rsp_valid, rsp_err
  );

  modport slave (
    input  valid, addr, data, rsp_ready,
    output ready, rsp_valid, rsp_err
  );
endinterface

// File: rtl/xdma_finish_sender.sv
// Turns a held finish request into one MMIO write of {from, dma_id} to the previous hop's finish register,
// acknowledging upstream only once the write response is back; error responses are re-issued up to MaxRetries.
module xdma_finish_sender #(
  parameter int unsigned          AddrWidth        = 48,
  parameter int unsigned          DataWidth        = 64,
  parameter int unsigned          IdWidth          = 8,
  parameter logic [AddrWidth-1:0] ClusterSize      = 48'h0010_0000,
  parameter logic [AddrWidth-1:0] MainMemBaseAddr  = 48'h8000_0000,
  parameter logic [AddrWidth-1:0] MainMemEndAddr   = 48'h1_0000_0000,
  parameter logic [AddrWidth-1:0] MMIOFinishOffset = 48'h40,
  parameter int unsigned          MaxRetries       = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] cluster_base_addr_i,
  input  logic                 finish_req_valid_i,
  output logic                 finish_req_ready_o,
  input  logic [AddrWidth-1:0] remote_addr_i,
  input  logic [IdWidth-1:0]   dma_id_i,
  xdma_finish_sender_if.master wr,
  output logic                 err_o,
  input  logic                 err_clear_i,
  output logic [15:0]          sent_cnt_o
);

  localparam int unsigned          RetryW      = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  localparam logic [RetryW-1:0]    RetryMax    = RetryW'(MaxRetries);
  localparam logic [AddrWidth-1:0] ClusterMask = ~(ClusterSize - AddrWidth'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_e;

  state_e                 state_q;
  logic [RetryW-1:0]      retry_q;
  logic                   wr_valid_q, rsp_ready_q, done_q, err_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   data_q;
  logic [15:0]            sent_cnt_q;
  logic [AddrWidth-1:0]   fin_addr;
  logic [DataWidth-1:0]   fin_data;

  // Finish register sits just below the end of the region that owns the remote address.
  always_comb begin
    if (remote_addr_i >= MainMemBaseAddr) begin
      fin_addr = MainMemEndAddr - MMIOFinishOffset;
    end else begin
      fin_addr = (remote_addr_i & ClusterMask) + ClusterSize - MMIOFinishOffset;
    end
    fin_data                       = '0;
    fin_data[IdWidth-1:0]          = dma_id_i;
    fin_data[IdWidth +: AddrWidth] = cluster_base_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      wr_valid_q  <= 1'b0;
      rsp_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sent_cnt_q  <= '0;
    end else begin
      wr_valid_q  <= 1'b0;
      rsp_ready_q <= 1'b0;
      done_q      <= 1'b0;
      if (err_clear_i) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (finish_req_valid_i) begin
            addr_q     <= fin_addr;
            data_q     <= fin_data;
            retry_q    <= '0;
            wr_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr.ready) begin
            rsp_ready_q <= 1'b1;
            state_q     <= WAIT_RSP;
          end else begin
            wr_valid_q <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (wr.rsp_valid) begin
            if (wr.rsp_err && (retry_q < RetryMax)) begin
              retry_q    <= retry_q + RetryW'(1);
              wr_valid_q <= 1'b1;
              state_q    <= ISSUE;
            end else begin
              // Placed after the clear above so a simultaneous set wins.
              if (wr.rsp_err) err_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            rsp_ready_q <= 1'b1;
          end
        end
        DONE: begin
          sent_cnt_q <= sent_cnt_q + 16'd1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr.valid           = wr_valid_q;
  assign wr.addr            = addr_q;
  assign wr.data            = data_q;
  assign wr.rsp_ready       = rsp_ready_q;
  assign finish_req_ready_o = done_q;
  assign err_o              = err_q;
  assign sent_cnt_o         = sent_cnt_q;

endmodule

// File: tb/tb_xdma_finish_sender.sv
// Directed plus randomized finish transactions checked against an arithmetic reference model.
module tb_xdma_finish_sender;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 8;
  localparam longint unsigned CS   = 64'h0010_0000;
  localparam longint unsigned MB   = 64'h8000_0000;
  localparam longint unsigned ME   = 64'h1_0000_0000;
  localparam longint unsigned OFF  = 64'h40;
  localparam int              MAXR = 3;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] cluster_base_addr_i = '0;
  logic [AW-1:0] remote_addr_i       = '0;
  logic [IW-1:0] dma_id_i            = '0;
  logic          finish_req_valid_i  = 1'b0;
  logic          finish_req_ready_o;
  logic          err_o;
  logic          err_clear_i = 1'b0;
  logic [15:0]   sent_cnt_o;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = '0;
  logic        exp_err  = 1'b0;

  xdma_finish_sender_if #(.AddrWidth(AW), .DataWidth(DW)) wr ();

  xdma_finish_sender dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .cluster_base_addr_i(cluster_base_addr_i),
    .finish_req_valid_i (finish_req_valid_i),
    .finish_req_ready_o (finish_req_ready_o),
    .remote_addr_i      (remote_addr_i),
    .dma_id_i           (dma_id_i),
    .wr                 (wr),
    .err_o              (err_o),
    .err_clear_i        (err_clear_i),
    .sent_cnt_o         (sent_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Finish register = end of the owning region minus the offset.
  function automatic logic [63:0] model_addr(input logic [47:0] a);
    longint unsigned au = 64'(a);
    longint unsigned region_end;
    if (au >= MB) region_end = ME;
    else region_end = (au / CS + 1) * CS;
    return (region_end - OFF) % (64'd1 << 48);
  endfunction

  function automatic logic [63:0] model_data(input logic [47:0] base, input logic [7:0] id);
    return 64'(base) * 256 + 64'(id);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, finish_req_ready_o, 0);
    check({tag, "_wr_valid"}, wr.valid, 0);
    check({tag, "_rsp_ready"}, wr.rsp_ready, 0);
    check({tag, "_addr"}, wr.addr, 0);
    check({tag, "_data"}, wr.data, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_cnt"}, sent_cnt_o, 0);
  endtask

  // One full finish: n_err error responses are returned before an OK (or until retries run out).
  task automatic do_finish(input logic [47:0] ra, input logic [7:0] id, input logic [47:0] base,
                           input int stall, input int n_err, input bit clr_last);
    logic [63:0] ea;
    logic [63:0] ed;
    int n_issue;
    int gap;
    ea      = model_addr(ra);
    ed      = model_data(base, id);
    n_issue = (n_err > MAXR) ? MAXR + 1 : n_err + 1;
    remote_addr_i       = ra;
    dma_id_i            = id;
    cluster_base_addr_i = base;
    finish_req_valid_i  = 1'b1;
    tick();
    check("req_ready_busy", finish_req_ready_o, 0);
    // Upstream changes while busy must not disturb the captured request.
    remote_addr_i       = {16'($urandom), 32'($urandom)};
    dma_id_i            = 8'($urandom);
    cluster_base_addr_i = {16'($urandom), 32'($urandom)};
    for (int k = 0; k < n_issue; k++) begin
      check("issue_valid", wr.valid, 1);
      check("issue_addr", wr.addr, ea);
      check("issue_data", wr.data, ed);
      check("issue_rsp_ready", wr.rsp_ready, 0);
      for (int s = 0; s < stall; s++) begin
        wr.rsp_valid = 1'($urandom);
        wr.rsp_err   = 1'($urandom);
        tick();
        check("stall_valid", wr.valid, 1);
        check("stall_addr", wr.addr, ea);
        check("stall_data", wr.data, ed);
      end
      wr.rsp_valid = 1'b0;
      wr.rsp_err   = 1'b0;
      wr.ready     = 1'b1;
      tick();
      wr.ready = 1'b0;
      check("accept_valid_drop", wr.valid, 0);
      check("wait_rsp_ready", wr.rsp_ready, 1);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_rsp_ready", wr.rsp_ready, 1);
        check("gap_req_ready", finish_req_ready_o, 0);
      end
      wr.rsp_valid = 1'b1;
      wr.rsp_err   = (k < n_err);
      if (k == n_issue - 1) err_clear_i = clr_last;
      tick();
      wr.rsp_valid = 1'b0;
      wr.rsp_err   = 1'b0;
      err_clear_i  = 1'b0;
      if (k < n_issue - 1) check("no_early_done", finish_req_ready_o, 0);
    end
    if (n_err > MAXR) exp_err = 1'b1;
    else if (clr_last) exp_err = 1'b0;
    check("done_req_ready", finish_req_ready_o, 1);
    check("done_no_reissue", wr.valid, 0);
    check("done_rsp_ready", wr.rsp_ready, 0);
    check("done_err", err_o, exp_err);
    finish_req_valid_i = 1'b0;
    exp_cnt++;
    tick();
    check("ready_single_pulse", finish_req_ready_o, 0);
    check("sent_cnt", sent_cnt_o, exp_cnt);
    check("err_sticky", err_o, exp_err);
  endtask

  initial begin
    wr.ready     = 1'b0;
    wr.rsp_valid = 1'b0;
    wr.rsp_err   = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_ni = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    do_finish(48'h0010_0200, 8'h05, 48'h0030_0000, 0, 0, 1'b0);
    do_finish(48'h8000_1000, 8'hA7, 48'h0030_0000, 0, 0, 1'b0);
    do_finish(48'h7FFF_FFFF, 8'h11, 48'h0040_0000, 5, 0, 1'b0);
    do_finish(48'h0012_3456, 8'h22, 48'h0050_0000, 1, 2, 1'b0);
    check("err_after_retry_ok", err_o, 0);
    do_finish(48'h0000_0040, 8'h33, 48'h0060_0000, 0, 4, 1'b0);
    check("err_exhausted", err_o, 1);
    do_finish(48'h0020_0000, 8'h44, 48'h0070_0000, 0, 4, 1'b1);
    check("err_set_beats_clear", err_o, 1);
    do_finish(48'h0020_0000, 8'h45, 48'h0070_0000, 0, 0, 1'b0);
    check("err_held_over_ok", err_o, 1);
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    exp_err     = 1'b0;
    check("err_cleared", err_o, 0);

    for (int t = 0; t < 25; t++) begin
      logic [47:0] ra;
      if ($urandom_range(0, 1) == 0) ra = {17'h0, 31'($urandom)};
      else ra = {16'($urandom), 32'($urandom)};
      do_finish(ra, 8'($urandom), {16'($urandom), 32'($urandom)}, $urandom_range(0, 3),
                $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
    end

    // Reset while waiting for a response.
    remote_addr_i       = 48'h0010_0200;
    dma_id_i            = 8'h05;
    cluster_base_addr_i = 48'h0030_0000;
    finish_req_valid_i  = 1'b1;
    tick();
    wr.ready = 1'b1;
    tick();
    wr.ready = 1'b0;
    check("pre_reset_wait_rsp", wr.rsp_ready, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("midop_reset");
    finish_req_valid_i = 1'b0;
    tick();
    rst_ni       = 1'b1;
    exp_cnt      = '0;
    exp_err      = 1'b0;
    wr.rsp_valid = 1'b1;
    wr.rsp_err   = 1'b0;
    tick();
    wr.rsp_valid = 1'b0;
    tick();
    check_all_zero("stale_rsp_ignored");
    do_finish(48'h8000_0000, 8'h5A, 48'h0030_0000, 2, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
